// File: rtl/fwd_hazard_unit.sv
// EX operand bypass, load-use bubble insertion and dmem-wait freeze for the 5-stage RV32I pipeline.
// Optional perf counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned LU_BUBBLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_W-1:0]  id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [NUM_SRC*REG_W-1:0]  ex_rs,
   input  logic [NUM_SRC*XLEN-1:0]   ex_rf_data,
   input  logic                      ex_mem_read,
   input  logic [REG_W-1:0]          ex_rd,
   input  logic                      mem_load_regfile,
   input  logic [REG_W-1:0]          mem_rd,
   input  logic [XLEN-1:0]           mem_fwd_data,
   input  logic                      mem_mem_read,
   input  logic                      dmem_resp,
   input  logic                      wb_load_regfile,
   input  logic [REG_W-1:0]          wb_rd,
   input  logic [XLEN-1:0]           wb_data,
   output logic [NUM_SRC*XLEN-1:0]   ex_opnd,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic                      stall_front,
   output logic                      bubble_ex,
   output logic                      stall_all,
   output logic [31:0]               perf_lu_cnt,
   output logic [31:0]               perf_wait_cnt,
   output logic [31:0]               perf_fwd_cnt
);

   localparam logic [1:0] LuInit = 2'(LU_BUBBLES - 1);

   typedef enum logic [1:0] {StRun, StLu, StWait} state_e;

   state_e                        state_q, ret_q;
   logic [1:0]                    cnt_q;
   logic [NUM_SRC-1:0]            hold_valid_q;
   logic [NUM_SRC-1:0][XLEN-1:0]  hold_data_q;

   logic                          mem_wait;
   logic                          lu_hit;
   logic [NUM_SRC-1:0]            wb_hit;
   logic                          any_fwd;

   assign mem_wait = mem_mem_read & ~dmem_resp;

   // Operand select: MEM beats WB beats a value captured while frozen; x0 never forwards.
   always_comb begin
      fwd_sel = '0;
      ex_opnd = '0;
      wb_hit  = '0;
      any_fwd = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [REG_W-1:0] rs;
         logic [1:0]       sel;
         rs        = ex_rs[i*REG_W +: REG_W];
         wb_hit[i] = wb_load_regfile && (wb_rd != '0) && (wb_rd == rs);
         sel       = 2'd0;
         if (rs != '0) begin
            if (mem_load_regfile && (mem_rd != '0) && (mem_rd == rs)) begin
               sel = 2'd1;
            end else if (wb_hit[i]) begin
               sel = 2'd2;
            end else if (hold_valid_q[i]) begin
               sel = 2'd3;
            end
         end
         fwd_sel[i*2 +: 2] = sel;
         any_fwd           = any_fwd | (sel != 2'd0);
         unique case (sel)
            2'd1:    ex_opnd[i*XLEN +: XLEN] = mem_fwd_data;
            2'd2:    ex_opnd[i*XLEN +: XLEN] = wb_data;
            2'd3:    ex_opnd[i*XLEN +: XLEN] = hold_data_q[i];
            default: ex_opnd[i*XLEN +: XLEN] = ex_rf_data[i*XLEN +: XLEN];
         endcase
      end
   end

   always_comb begin
      lu_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used[i] && (id_rs[i*REG_W +: REG_W] == ex_rd)) begin
            lu_hit = 1'b1;
         end
      end
      lu_hit = lu_hit & ex_mem_read & (ex_rd != '0);
   end

   always_comb begin
      stall_front = 1'b0;
      bubble_ex   = 1'b0;
      stall_all   = 1'b0;
      if (rst_n) begin
         stall_all = mem_wait;
         unique case (state_q)
            StRun: begin
               // A pending dmem wait outranks the load-use hit; the hit is re-seen afterwards.
               stall_front = ~mem_wait & lu_hit;
               bubble_ex   = ~mem_wait & lu_hit;
            end
            StLu: begin
               stall_front = 1'b1;
               bubble_ex   = 1'b1;
            end
            StWait: stall_front = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StRun;
         ret_q   <= StRun;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mem_wait) begin
                  state_q <= StWait;
                  ret_q   <= StRun;
               end else if (lu_hit && (LU_BUBBLES > 1)) begin
                  state_q <= StLu;
                  cnt_q   <= LuInit;
               end
            end
            StLu: begin
               if (mem_wait) begin
                  state_q <= StWait;
                  ret_q   <= StLu;
               end else if (cnt_q == 2'd1) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            StWait: begin
               if (dmem_resp) begin
                  state_q <= ret_q;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // Results retiring from WB while EX is frozen would otherwise be lost to the stalled operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_valid_q <= '0;
         hold_data_q  <= '0;
      end else if (mem_wait) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_hit[i]) begin
               hold_valid_q[i] <= 1'b1;
               hold_data_q[i]  <= wb_data;
            end
         end
      end else begin
         hold_valid_q <= '0;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] perf_lu_q, perf_wait_q, perf_fwd_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_lu_q   <= '0;
         perf_wait_q <= '0;
         perf_fwd_q  <= '0;
      end else begin
         if (bubble_ex)             perf_lu_q   <= perf_lu_q + 32'd1;
         if (stall_all)             perf_wait_q <= perf_wait_q + 32'd1;
         if (!stall_all && any_fwd) perf_fwd_q  <= perf_fwd_q + 32'd1;
      end
   end

   assign perf_lu_cnt   = perf_lu_q;
   assign perf_wait_cnt = perf_wait_q;
   assign perf_fwd_cnt  = perf_fwd_q;
`else
   assign perf_lu_cnt   = 32'd0;
   assign perf_wait_cnt = 32'd0;
   assign perf_fwd_cnt  = 32'd0;
`endif

endmodule
